// File: rtl/systolic_pe_acc.sv
// rtl/systolic_pe_acc.sv - systolic MAC processing element with per-column result drain chain
// Define PE_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module systolic_pe_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] row_in,
  input  logic              row_vld_in,
  input  logic [DATA_W-1:0] col_in,
  input  logic              col_vld_in,
  input  logic              clr_in,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_vld_in,
  output logic [DATA_W-1:0] row_out,
  output logic              row_vld_out,
  output logic [DATA_W-1:0] col_out,
  output logic              col_vld_out,
  output logic              clr_out,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_vld_out,
  output logic              acc_ovf,
  output logic              drop_err
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                     state;
  logic signed [ACC_W-1:0]    acc;
  logic        [ACC_W-1:0]    pend;
  logic                       pend_vld;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    p_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    acc_next;
  logic                       fire;
  logic                       ovf_now;
  logic                       capture;

  assign fire    = row_vld_in & col_vld_in;
  assign prod    = $signed(row_in) * $signed(col_in);
  assign p_ext   = ACC_W'(prod);
  assign sum     = acc + p_ext;
  // Overflow only when both addends share a sign and the sum's sign differs.
  assign ovf_now = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign capture = clr_in && (state == ACC);

`ifdef PE_SAT_EN
  assign acc_next = !ovf_now ? sum :
                    acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign acc_next = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      row_out     <= '0;
      row_vld_out <= 1'b0;
      col_out     <= '0;
      col_vld_out <= 1'b0;
      clr_out     <= 1'b0;
      res_out     <= '0;
      res_vld_out <= 1'b0;
      acc_ovf     <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      row_out     <= row_in;
      row_vld_out <= row_vld_in;
      col_out     <= col_in;
      col_vld_out <= col_vld_in;
      clr_out     <= clr_in;

      if (clr_in) begin
        acc   <= fire ? p_ext : '0;
        state <= fire ? ACC : IDLE;
      end else if (fire) begin
        acc   <= acc_next;
        state <= ACC;
        if (ovf_now) acc_ovf <= 1'b1;
      end

      // Upstream traffic always wins the output register; the local result waits.
      if (res_vld_in) begin
        res_out     <= res_in;
        res_vld_out <= 1'b1;
      end else if (pend_vld) begin
        res_out     <= pend;
        res_vld_out <= 1'b1;
      end else begin
        res_vld_out <= 1'b0;
      end

      if (capture) begin
        pend     <= acc;
        pend_vld <= 1'b1;
        if (pend_vld && res_vld_in) drop_err <= 1'b1;
      end else if (pend_vld && !res_vld_in) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule
